// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC generator with a direct-mapped branch target buffer
module fetch_pc_unit #(
  parameter int WIDTH = 32,
  parameter int BTB_BITS = 6,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_f,
  input  logic             predict_taken,
  input  logic             ex_is_branch,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             ex_taken,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_mispredict,
  input  logic [WIDTH-1:0] ex_redirect_pc,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] pc_plus4_f,
  output logic             btb_hit_f,
  output logic             pred_taken_f,
  output logic [WIDTH-1:0] pred_target_f
);
  localparam int N = 1 << BTB_BITS;
  localparam int TW = WIDTH - BTB_BITS - 2;
  logic [N-1:0] valid;
  logic [TW-1:0] tag_q [N];
  logic [WIDTH-3:0] tgt_q [N];
  logic [BTB_BITS-1:0] f_idx, ex_idx;
  logic btb_wr;
  logic unused;
  assign unused = ^{ex_pc[1:0], ex_target[1:0]};
  assign f_idx = pc_f[BTB_BITS+1:2];
  assign ex_idx = ex_pc[BTB_BITS+1:2];
  assign btb_wr = ex_is_branch && ex_taken;
  assign pc_plus4_f = pc_f + WIDTH'(4);
  // combinational lookup on pc_f sees the contents before any same-cycle write
  always_comb begin
    btb_hit_f = valid[f_idx] && (tag_q[f_idx] == pc_f[WIDTH-1:BTB_BITS+2]);
    pred_taken_f = btb_hit_f && predict_taken;
    pred_target_f = btb_hit_f ? {tgt_q[f_idx], 2'b00} : pc_plus4_f;
  end
  // next-PC selection and valid bits; mispredict redirect beats a stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f <= RESET_PC;
      valid <= '0;
    end else begin
      if (ex_mispredict) pc_f <= ex_redirect_pc;
      else if (!stall_f) pc_f <= pred_taken_f ? pred_target_f : pc_plus4_f;
      if (btb_wr) valid[ex_idx] <= 1'b1;
    end
  end
  // tag/target storage is gated by valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      tag_q[ex_idx] <= ex_pc[WIDTH-1:BTB_BITS+2];
      tgt_q[ex_idx] <= ex_target[WIDTH-1:2];
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed and random checks of fetch_pc_unit against a behavioural model
module tb_fetch_pc_unit;
  logic clk = 0, reset = 1;
  logic stall_f = 0, predict_taken = 0, ex_is_branch = 0, ex_taken = 0, ex_mispredict = 0;
  logic [31:0] ex_pc = 0, ex_target = 0, ex_redirect_pc = 0;
  logic [31:0] pc_f, pc_plus4_f, pred_target_f;
  logic btb_hit_f, pred_taken_f;
  int checks = 0, failures = 0;
  logic [31:0] m_pc;
  bit m_valid [64];
  logic [31:0] m_owner [64];
  logic [31:0] m_tgt [64];
  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .predict_taken(predict_taken),
    .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_mispredict(ex_mispredict), .ex_redirect_pc(ex_redirect_pc), .pc_f(pc_f),
    .pc_plus4_f(pc_plus4_f), .btb_hit_f(btb_hit_f), .pred_taken_f(pred_taken_f),
    .pred_target_f(pred_target_f)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
  endtask
  // lookup in the model: an entry belongs to the PC whose word address shares index and upper bits
  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = (pc / 4) % 64;
    return m_valid[i] && (m_owner[i] / 256 == pc / 256);
  endfunction
  task automatic cyc(input logic st, input logic pt, input logic br, input logic [31:0] ep,
                     input logic tk, input logic [31:0] et, input logic mp, input logic [31:0] rp);
    bit h;
    logic [31:0] tgt, nxt;
    int i;
    stall_f = st; predict_taken = pt; ex_is_branch = br; ex_pc = ep;
    ex_taken = tk; ex_target = et; ex_mispredict = mp; ex_redirect_pc = rp;
    #1;
    i = (m_pc / 4) % 64;
    h = m_hit(m_pc);
    tgt = h ? m_tgt[i] : m_pc + 32'd4;
    chk("pc_f", pc_f, m_pc);
    chk("pc_plus4_f", pc_plus4_f, m_pc + 32'd4);
    chk("btb_hit_f", {31'b0, btb_hit_f}, {31'b0, h});
    chk("pred_taken_f", {31'b0, pred_taken_f}, {31'b0, h & pt});
    chk("pred_target_f", pred_target_f, tgt);
    nxt = mp ? rp : st ? m_pc : (h && pt) ? tgt : m_pc + 32'd4;
    @(posedge clk);
    m_pc = nxt;
    if (br && tk) begin
      i = (ep / 4) % 64;
      m_valid[i] = 1;
      m_owner[i] = ep;
      m_tgt[i] = et & ~32'd3;
    end
    @(negedge clk);
  endtask
  task automatic idle(input logic pt);
    cyc(0, pt, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic go(input logic [31:0] rp);
    cyc(0, 0, 0, 0, 0, 0, 1, rp);
  endtask
  task automatic reset_now();
    reset = 1;
    #1;
    model_reset();
    chk("rst_pc_f", pc_f, 32'h0);
    chk("rst_hit", {31'b0, btb_hit_f}, 32'h0);
    chk("rst_pred_taken", {31'b0, pred_taken_f}, 32'h0);
    chk("rst_pred_target", pred_target_f, 32'h4);
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    model_reset();
    #1;
    chk("por_pc_f", pc_f, 32'h0);
    chk("por_hit", {31'b0, btb_hit_f}, 32'h0);
    chk("por_pred_target", pred_target_f, 32'h4);
    @(negedge clk);
    reset = 0;
    repeat (4) idle(0);
    cyc(0, 0, 1, 32'h10, 1, 32'h80, 0, 0);
    go(32'h10);
    idle(1);
    chk("taken_to_80", pc_f, 32'h80);
    go(32'h10);
    idle(0);
    chk("not_taken_to_14", pc_f, 32'h14);
    cyc(0, 0, 1, 32'h110, 1, 32'h200, 0, 0);
    go(32'h10);
    idle(1);
    go(32'h110);
    idle(1);
    chk("alias_target", pc_f, 32'h200);
    cyc(0, 0, 1, 32'h200, 0, 32'h400, 1, 32'h200);
    idle(1);
    cyc(0, 1, 1, 32'h204, 1, 32'h303, 0, 0);
    idle(1);
    cyc(1, 1, 0, 0, 0, 0, 1, 32'h40);
    chk("stall_mispredict", pc_f, 32'h40);
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("stall_hold", pc_f, 32'h40);
    go(32'hFFFF_FFFC);
    idle(0);
    chk("wrap", pc_f, 32'h0);
    cyc(0, 0, 1, 32'h4, 1, 32'h100, 1, 32'h4);
    stall_f = 0; predict_taken = 1; ex_is_branch = 0; ex_mispredict = 1; ex_redirect_pc = 32'h800;
    reset_now();
    go(32'h10);
    idle(1);
    go(32'h4);
    idle(1);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ep, et, rp;
      ep = {22'($urandom_range(0, 3)), 10'($urandom)};
      et = {22'($urandom_range(0, 3)), 10'($urandom)};
      rp = {22'($urandom_range(0, 3)), 8'($urandom), 2'b00};
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, ep,
          $urandom_range(0, 2) != 0, et, $urandom_range(0, 4) == 0, rp);
      if (n == 200) reset_now();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
